alu_arbiter: RTL

Round-robin arbiter and sequencer that shares one combinational 4-bit ALU (3-bit opcode, operand_a, operand_b, result, overflow) between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures result and overflow, and returns them tagged with the requester ID. It also keeps per-requester grant counters. It sits between the ALU and its clients; the ALU itself stays outside this block.

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Requests are granted round-robin, executed one at a time, and returned
// tagged with the requester ID. A grant counter is kept per requester.
//
// Handshakes (all channels): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and payload stable
// until that edge. req*_ready is a pure function of the FSM state and the
// request valids; it never looks at rsp_ready. rsp_valid/rsp_* are held
// stable while rsp_valid && !rsp_ready.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    // requester 0
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    // requester 1
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    // external ALU
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    // response
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    // status
    output logic             busy,
    output logic [CNTW-1:0]  gnt_cnt0,
    output logic [CNTW-1:0]  gnt_cnt1,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_last_grant;
    logic [OPW-1:0]   r_alu_opcode;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_overflow;
    logic [CNTW-1:0]  r_gnt_cnt0;
    logic [CNTW-1:0]  r_gnt_cnt1;

    logic             w_idle;
    logic             w_grant;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic [OPW-1:0]   w_sel_opcode;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    // Round-robin pick: a lone requester wins; on a tie the one that did not
    // win last time wins. Ready is only offered in IDLE to the winner.
    always_comb begin
        w_idle  = (r_state == S_IDLE);
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
        w_ready0     = w_idle && req0_valid && !w_grant;
        w_ready1     = w_idle && req1_valid && w_grant;
        w_accept     = w_ready0 || w_ready1;
        w_sel_opcode = w_grant ? req1_opcode : req0_opcode;
        w_sel_a      = w_grant ? req1_a      : req0_a;
        w_sel_b      = w_grant ? req1_b      : req0_b;
    end

    // Sequencer: accept -> one EXEC cycle for the ALU to settle -> hold the
    // response until consumed. alu_* and rsp_* keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_alu_opcode   <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
            r_gnt_cnt0     <= '0;
            r_gnt_cnt1     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_opcode <= w_sel_opcode;
                        r_alu_a      <= w_sel_a;
                        r_alu_b      <= w_sel_b;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_grant) begin
                            r_gnt_cnt1 <= r_gnt_cnt1 + CNT_ONE;
                        end else begin
                            r_gnt_cnt0 <= r_gnt_cnt0 + CNT_ONE;
                        end
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_result   <= alu_result;
                    r_rsp_overflow <= alu_overflow;
                    r_rsp_valid    <= 1'b1;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready   = w_ready0;
    assign req1_ready   = w_ready1;
    assign alu_opcode   = r_alu_opcode;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;
    assign busy         = (r_state != S_IDLE);
    assign gnt_cnt0     = r_gnt_cnt0;
    assign gnt_cnt1     = r_gnt_cnt1;
    assign dbg_state    = r_state;

endmodule
